pc_sequencer: RTL

//  Next-PC scheduler for the 5-stage MIPS pipeline. Arbitrates the redirect sources
//  (exception, eret, branch, jump, sequential) and the load-use hazard into one word

---
 rtl/pc_sequencer.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Next-PC arbiter with post-redirect bubble FSM for the 5-stage pipeline.
// Optional PCSEQ_STALL_CNT_EN adds a saturating stall_cnt output.
module pc_sequencer #(
  parameter logic [29:0] RESET_VEC   = 30'h0000000D,
  parameter logic [29:0] EXC_VEC     = 30'h00000060,
  parameter int unsigned BR_BUBBLES  = 1,
  parameter int unsigned CP0_BUBBLES = 2,
  parameter int unsigned CNT_W       = 3
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [29:0] pc,
  input  logic        hazard,
  input  logic        br_taken,
  input  logic [29:0] br_target,
  input  logic        jmp_taken,
  input  logic [29:0] jmp_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [29:0] epc,
  output logic [29:0] npc,
  output logic        pc_stall,
  output logic        if_flush,
  output logic [1:0]  seq_state
`ifdef PCSEQ_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_HOLD  = 2'd1,
    CP0_HOLD = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] BR_CNT  = CNT_W'(BR_BUBBLES);
  localparam logic [CNT_W-1:0] CP0_CNT = CNT_W'(CP0_BUBBLES);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(negedge Clk) begin
    if (Reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    npc       = pc + 30'd1;
    pc_stall  = 1'b0;
    if_flush  = 1'b0;
    state_nxt = state;
    cnt_nxt   = cnt;
    if (Reset) begin
      npc       = RESET_VEC;
      if_flush  = 1'b1;
      state_nxt = RUN;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        RUN, BR_HOLD: begin
          if (exc_req || eret_req) begin
            npc      = exc_req ? EXC_VEC : epc;
            if_flush = 1'b1;
            if (CP0_BUBBLES > 0) begin
              state_nxt = CP0_HOLD;
              cnt_nxt   = CP0_CNT;
            end else begin
              state_nxt = RUN;
              cnt_nxt   = '0;
            end
          end else if (state == BR_HOLD) begin
            // Branch/jump/hazard are don't-care while draining.
            npc      = pc;
            pc_stall = 1'b1;
            if_flush = 1'b1;
            cnt_nxt  = cnt - ONE;
            if (cnt <= ONE) begin
              state_nxt = RUN;
              cnt_nxt   = '0;
            end
          end else if (br_taken || jmp_taken) begin
            npc      = br_taken ? br_target : jmp_target;
            if_flush = 1'b1;
            if (BR_BUBBLES > 0) begin
              state_nxt = BR_HOLD;
              cnt_nxt   = BR_CNT;
            end
          end else if (hazard) begin
            npc      = pc;
            pc_stall = 1'b1;
          end
        end
        CP0_HOLD: begin
          npc      = pc;
          pc_stall = 1'b1;
          if_flush = 1'b1;
          cnt_nxt  = cnt - ONE;
          if (cnt <= ONE) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        end
        default: begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign seq_state = state;

`ifdef PCSEQ_STALL_CNT_EN
  always_ff @(negedge Clk) begin
    if (Reset)
      stall_cnt <= '0;
    else if (pc_stall && (stall_cnt != 32'hFFFFFFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule
